// File: rtl/tone_mixer_i2s.sv
// N-voice square-wave tone mixer with pan masks, stepped master volume and an I2S serializer.
// Define AUDIO_VOL_BCD_EN to add the BCD volume display ports vol_ten / vol_uni.
module tone_mixer_i2s #(
   parameter int VOICES     = 4,
   parameter int DIV_W      = 22,
   parameter int SAMPLE_W   = 16,
   parameter int VOL_LEVELS = 16,
   parameter int VOL_RESET  = 8,
   parameter int AMP_STEP   = 2048
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [VOICES*DIV_W-1:0]         note_div,
   input  logic [VOICES-1:0]               pan_l,
   input  logic [VOICES-1:0]               pan_r,
   input  logic                            vol_up,
   input  logic                            vol_dn,
   output logic [$clog2(VOL_LEVELS)-1:0]   vol_level,
`ifdef AUDIO_VOL_BCD_EN
   output logic [3:0]                      vol_ten,
   output logic [3:0]                      vol_uni,
`endif
   output logic                            audio_mclk,
   output logic                            audio_sck,
   output logic                            audio_lrck,
   output logic                            audio_sdin
);

   localparam int VOL_W = $clog2(VOL_LEVELS);
   localparam int SUM_W = SAMPLE_W + $clog2(VOICES) + 1;
   localparam logic [VOL_W-1:0] VOL_MAX  = VOL_W'(VOL_LEVELS - 1);
   localparam logic [VOL_W-1:0] VOL_INIT = VOL_W'(VOL_RESET);
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (SAMPLE_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (SAMPLE_W - 1)));
   localparam logic [5:0] SW6 = 6'(SAMPLE_W);

   // ------------------------------------------------------------------
   // Frame counter and derived I2S clocks
   // ------------------------------------------------------------------
   logic [9:0] cnt_reg;
   logic [9:0] cnt_next;

   assign cnt_next = cnt_reg + 10'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign audio_mclk = cnt_reg[1];
   assign audio_sck  = cnt_reg[3];
   assign audio_lrck = cnt_reg[9];

   // ------------------------------------------------------------------
   // Master volume
   // ------------------------------------------------------------------
   logic [VOL_W-1:0] vol_level_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vol_level_reg <= VOL_INIT;
      end else if (vol_up && !vol_dn && vol_level_reg != VOL_MAX) begin
         vol_level_reg <= vol_level_reg + VOL_W'(1);
      end else if (vol_dn && !vol_up && vol_level_reg != '0) begin
         vol_level_reg <= vol_level_reg - VOL_W'(1);
      end
   end

   assign vol_level = vol_level_reg;

`ifdef AUDIO_VOL_BCD_EN
   logic [3:0] vol_ten_reg;
   logic [3:0] vol_uni_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vol_ten_reg <= 4'(VOL_RESET / 10);
         vol_uni_reg <= 4'(VOL_RESET % 10);
      end else begin
         vol_ten_reg <= 4'(int'(vol_level_reg) / 10);
         vol_uni_reg <= 4'(int'(vol_level_reg) % 10);
      end
   end

   assign vol_ten = vol_ten_reg;
   assign vol_uni = vol_uni_reg;
`endif

   // ------------------------------------------------------------------
   // Tone voices
   // ------------------------------------------------------------------
   logic [VOICES-1:0] phase_vec;
   logic [VOICES-1:0] on_vec;

   genvar gi;
   generate
      for (gi = 0; gi < VOICES; gi++) begin : g_voice
         logic [DIV_W-1:0] div_in;
         logic [DIV_W-1:0] div_reg;
         logic [DIV_W-1:0] count_reg;
         logic             phase_reg;

         assign div_in = note_div[gi*DIV_W +: DIV_W];

         // A new divider restarts the voice; dividers below 2 park it silent.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               div_reg   <= '0;
               count_reg <= '0;
               phase_reg <= 1'b0;
            end else begin
               div_reg <= div_in;
               if (div_in != div_reg || div_reg < DIV_W'(2)) begin
                  count_reg <= '0;
                  phase_reg <= 1'b0;
               end else if (count_reg == div_reg - DIV_W'(1)) begin
                  count_reg <= '0;
                  phase_reg <= ~phase_reg;
               end else begin
                  count_reg <= count_reg + DIV_W'(1);
               end
            end
         end

         assign phase_vec[gi] = phase_reg;
         assign on_vec[gi]    = (div_reg >= DIV_W'(2));
      end
   endgenerate

   // ------------------------------------------------------------------
   // Stereo mixer with saturation
   // ------------------------------------------------------------------
   logic [SUM_W-1:0]        amp;
   logic signed [SUM_W-1:0] amp_s;
   logic signed [SUM_W-1:0] contrib;
   logic signed [SUM_W-1:0] sum_l;
   logic signed [SUM_W-1:0] sum_r;
   logic [SAMPLE_W-1:0]     mix_l_next;
   logic [SAMPLE_W-1:0]     mix_r_next;
   logic [SAMPLE_W-1:0]     mix_l_reg;
   logic [SAMPLE_W-1:0]     mix_r_reg;

   assign amp   = SUM_W'(vol_level_reg) * SUM_W'(AMP_STEP);
   assign amp_s = $signed(amp);

   function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W-1:0] c;
      if (s > SAT_MAX) begin
         c = SAT_MAX;
      end else if (s < SAT_MIN) begin
         c = SAT_MIN;
      end else begin
         c = s;
      end
      return c[SAMPLE_W-1:0];
   endfunction

   always_comb begin
      contrib = '0;
      sum_l   = '0;
      sum_r   = '0;
      for (int v = 0; v < VOICES; v++) begin
         contrib = '0;
         if (on_vec[v]) begin
            contrib = phase_vec[v] ? amp_s : -amp_s;
         end
         if (pan_l[v]) begin
            sum_l = sum_l + contrib;
         end
         if (pan_r[v]) begin
            sum_r = sum_r + contrib;
         end
      end
      mix_l_next = saturate(sum_l);
      mix_r_next = saturate(sum_r);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mix_l_reg <= '0;
         mix_r_reg <= '0;
      end else begin
         mix_l_reg <= mix_l_next;
         mix_r_reg <= mix_r_next;
      end
   end

   // ------------------------------------------------------------------
   // Frame sample latch and I2S serializer
   // ------------------------------------------------------------------
   logic [SAMPLE_W-1:0] hold_l_reg;
   logic [SAMPLE_W-1:0] hold_r_reg;
   logic [SAMPLE_W-1:0] slot_word;
   logic [SAMPLE_W-1:0] slot_shift;
   logic [5:0]          period_next;
   logic [5:0]          bit_sel;
   logic                sdin_next;
   logic                sdin_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_l_reg <= '0;
         hold_r_reg <= '0;
      end else if (cnt_reg == 10'd1023) begin
         hold_l_reg <= mix_l_reg;
         hold_r_reg <= mix_r_reg;
      end
   end

   // The bit is chosen for the sck period about to begin, giving the one-bit I2S delay.
   always_comb begin
      slot_word   = cnt_next[9] ? hold_r_reg : hold_l_reg;
      period_next = {1'b0, cnt_next[8:4]};
      bit_sel     = SW6 - period_next;
      slot_shift  = slot_word >> bit_sel;
      sdin_next   = 1'b0;
      if (period_next != 6'd0 && period_next <= SW6) begin
         sdin_next = slot_shift[0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sdin_reg <= 1'b0;
      end else if (cnt_reg[3:0] == 4'hF) begin
         sdin_reg <= sdin_next;
      end
   end

   assign audio_sdin = sdin_reg;

endmodule

// File: tb/tb_tone_mixer_i2s.sv
// Directed testbench for tone_mixer_i2s: reset state, voice/mix/saturation, volume edges, restart, I2S frames.
module tb_tone_mixer_i2s;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [87:0] note_div = '0;
   logic [3:0]  pan_l = '0;
   logic [3:0]  pan_r = '0;
   logic        vol_up = 1'b0;
   logic        vol_dn = 1'b0;
   logic [3:0]  vol_level;
   logic        audio_mclk;
   logic        audio_sck;
   logic        audio_lrck;
   logic        audio_sdin;
`ifdef AUDIO_VOL_BCD_EN
   logic [3:0]  vol_ten;
   logic [3:0]  vol_uni;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] l_word;
   logic [15:0] r_word;
   int          nz;

   tone_mixer_i2s dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .note_div   (note_div),
      .pan_l      (pan_l),
      .pan_r      (pan_r),
      .vol_up     (vol_up),
      .vol_dn     (vol_dn),
      .vol_level  (vol_level),
`ifdef AUDIO_VOL_BCD_EN
      .vol_ten    (vol_ten),
      .vol_uni    (vol_uni),
`endif
      .audio_mclk (audio_mclk),
      .audio_sck  (audio_sck),
      .audio_lrck (audio_lrck),
      .audio_sdin (audio_sdin)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic set_voice(input int v, input logic [21:0] d);
      note_div[v*22 +: 22] = d;
   endtask

   task automatic pulse(input logic u, input logic d);
      @(negedge clk);
      vol_up = u;
      vol_dn = d;
      @(negedge clk);
      vol_up = 1'b0;
      vol_dn = 1'b0;
   endtask

   // Returns on the negedge where the frame counter has just wrapped to 0.
   task automatic wait_frame_start();
      logic prev;
      logic found;
      found = 1'b0;
      prev  = audio_lrck;
      for (int i = 0; i < 2100 && !found; i++) begin
         @(negedge clk);
         if (prev && !audio_lrck) found = 1'b1;
         prev = audio_lrck;
      end
      check_eq("frame_sync", {31'd0, found}, 32'd1);
   endtask

   // Assumes the counter is 0 at the current negedge; samples mid-sck-period.
   task automatic read_frame_now(output logic [15:0] l, output logic [15:0] r);
      int p;
      l = '0;
      r = '0;
      for (int k = 0; k < 1024; k++) begin
         if (k > 0) @(negedge clk);
         if (k % 16 == 8) begin
            p = (k >> 4) & 31;
            if (p >= 1 && p <= 16) begin
               if (k < 512) l[16-p] = audio_sdin;
               else         r[16-p] = audio_sdin;
            end
         end
      end
   endtask

   task automatic get_frame(output logic [15:0] l, output logic [15:0] r);
      wait_frame_start();
      read_frame_now(l, r);
   endtask

   initial begin
      // Reset defaults
      repeat (4) @(negedge clk);
      check_eq("rst vol_level", 32'(vol_level), 32'd8);
      check_eq("rst sdin", 32'(audio_sdin), 32'd0);
      check_eq("rst lrck", 32'(audio_lrck), 32'd0);
      check_eq("rst sck", 32'(audio_sck), 32'd0);
`ifdef AUDIO_VOL_BCD_EN
      check_eq("rst vol_ten", 32'(vol_ten), 32'd0);
      check_eq("rst vol_uni", 32'(vol_uni), 32'd8);
`endif
      rst_n = 1'b1;
      nz = 0;
      for (int k = 0; k < 1024; k++) begin
         if (k > 0) @(negedge clk);
         if (audio_sdin) nz++;
         if (k == 2)   check_eq("mclk cnt2", 32'(audio_mclk), 32'd1);
         if (k == 7)   check_eq("sck cnt7", 32'(audio_sck), 32'd0);
         if (k == 8)   check_eq("sck cnt8", 32'(audio_sck), 32'd1);
         if (k == 16)  check_eq("sck cnt16", 32'(audio_sck), 32'd0);
         if (k == 24)  check_eq("sck cnt24", 32'(audio_sck), 32'd1);
         if (k == 511) check_eq("lrck cnt511", 32'(audio_lrck), 32'd0);
         if (k == 512) check_eq("lrck cnt512", 32'(audio_lrck), 32'd1);
      end
      check_eq("first frame sdin ones", 32'(nz), 32'd0);

      // Single voice, left pan, level 8: amp 16384
      pan_l = 4'b0001;
      pan_r = 4'b0000;
      wait_frame_start();
      repeat (100) @(negedge clk);
      set_voice(0, 22'd100);
      get_frame(l_word, r_word);
      check_eq("voice pos left", 32'(l_word), 32'h4000);
      check_eq("voice pos right", 32'(r_word), 32'h0000);
      set_voice(0, 22'd0);
      repeat (4) @(negedge clk);
      wait_frame_start();
      set_voice(0, 22'd100);
      get_frame(l_word, r_word);
      check_eq("voice neg left", 32'(l_word), 32'hC000);
      check_eq("voice neg right", 32'(r_word), 32'h0000);

      // Saturation: 4 voices at level 15
      note_div = '0;
      repeat (4) @(negedge clk);
      repeat (7) pulse(1'b1, 1'b0);
      check_eq("vol to 15", 32'(vol_level), 32'd15);
      pan_l = 4'hF;
      pan_r = 4'hF;
      wait_frame_start();
      repeat (50) @(negedge clk);
      note_div = {4{22'd50}};
      get_frame(l_word, r_word);
      check_eq("sat pos left", 32'(l_word), 32'h7FFF);
      check_eq("sat pos right", 32'(r_word), 32'h7FFF);
      note_div = '0;
      repeat (4) @(negedge clk);
      wait_frame_start();
      note_div = {4{22'd50}};
      get_frame(l_word, r_word);
      check_eq("sat neg left", 32'(l_word), 32'h8000);
      check_eq("sat neg right", 32'(r_word), 32'h8000);

      // Volume edges
      repeat (20) pulse(1'b0, 1'b1);
      check_eq("vol floor", 32'(vol_level), 32'd0);
      get_frame(l_word, r_word);
      get_frame(l_word, r_word);
      check_eq("vol0 left", 32'(l_word), 32'h0000);
      check_eq("vol0 right", 32'(r_word), 32'h0000);
      pulse(1'b1, 1'b1);
      check_eq("vol both at 0", 32'(vol_level), 32'd0);
      repeat (20) pulse(1'b1, 1'b0);
      check_eq("vol ceiling", 32'(vol_level), 32'd15);
      pulse(1'b1, 1'b1);
      check_eq("vol both at 15", 32'(vol_level), 32'd15);
      @(negedge clk);
      vol_dn = 1'b1;
      @(negedge clk);
      vol_dn = 1'b0;
      check_eq("vol dn 1 cycle", 32'(vol_level), 32'd14);
      pulse(1'b1, 1'b0);
      check_eq("vol back to 15", 32'(vol_level), 32'd15);

      // Divider change mid-period, level 15: amp 30720 (0x7800 / 0x8800)
      note_div = '0;
      pan_l = 4'b0001;
      pan_r = 4'b0000;
      repeat (4) @(negedge clk);
      wait_frame_start();
      set_voice(0, 22'd100);
      repeat (550) @(negedge clk);
      set_voice(0, 22'd40);
      get_frame(l_word, r_word);
      check_eq("restart f1 left", 32'(l_word), 32'h7800);
      check_eq("restart f1 right", 32'(r_word), 32'h0000);
      get_frame(l_word, r_word);
      check_eq("restart f2 left", 32'(l_word), 32'h7800);
      get_frame(l_word, r_word);
      check_eq("restart f3 left", 32'(l_word), 32'h8800);

      // Silence via div = 1
      set_voice(0, 22'd1);
      get_frame(l_word, r_word);
      get_frame(l_word, r_word);
      check_eq("silent left", 32'(l_word), 32'h0000);

`ifdef AUDIO_VOL_BCD_EN
      repeat (3) pulse(1'b0, 1'b1);
      repeat (2) @(negedge clk);
      check_eq("bcd level", 32'(vol_level), 32'd12);
      check_eq("bcd ten", 32'(vol_ten), 32'd1);
      check_eq("bcd uni", 32'(vol_uni), 32'd2);
`endif

      // Reset mid-frame aborts the frame; voice restarts on release
      set_voice(0, 22'd100);
      wait_frame_start();
      repeat (300) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("midrst vol_level", 32'(vol_level), 32'd8);
      check_eq("midrst lrck", 32'(audio_lrck), 32'd0);
      check_eq("midrst sdin", 32'(audio_sdin), 32'd0);
`ifdef AUDIO_VOL_BCD_EN
      check_eq("midrst vol_ten", 32'(vol_ten), 32'd0);
      check_eq("midrst vol_uni", 32'(vol_uni), 32'd8);
`endif
      rst_n = 1'b1;
      read_frame_now(l_word, r_word);
      check_eq("post rst f1 left", 32'(l_word), 32'h0000);
      check_eq("post rst f1 right", 32'(r_word), 32'h0000);
      get_frame(l_word, r_word);
      check_eq("post rst f2 left", 32'(l_word), 32'hC000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
